// File: rtl/sine_gen_pkg.sv
// sine_gen_pkg: shared state type and modulo-depth address adder for the sine phase generator.
package sine_gen_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    typedef struct packed {
        logic        wrap;
        logic [31:0] addr;
    } wrap_res_t;
    // Single conditional subtract is enough because both operands are always < depth.
    function automatic wrap_res_t wrap_add(input logic [31:0] addr, input logic [31:0] step, input logic [31:0] depth);
        logic [32:0] sum;
        logic [32:0] red;
        sum = {1'b0, addr} + {1'b0, step};
        red = sum - {1'b0, depth};
        wrap_add.wrap = (sum >= {1'b0, depth});
        wrap_add.addr = wrap_add.wrap ? 32'(red) : 32'(sum);
    endfunction
endpackage

// File: rtl/sample_tick_div.sv
// sample_tick_div: counts 0..div_p-1 while enabled and flags the last count as a one-cycle tick.
module sample_tick_div #(
    parameter  int unsigned div_p    = 4,
    localparam int unsigned cnt_w_lp = $clog2(div_p)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);
    logic [cnt_w_lp-1:0] r_cnt;
    assign tick_o = en_i && (r_cnt == cnt_w_lp'(div_p - 1));
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_cnt <= '0;
        else if (clear_i) r_cnt <= '0;
        else if (en_i) r_cnt <= tick_o ? '0 : r_cnt + cnt_w_lp'(1);
    end
endmodule

// File: rtl/sine_phase_gen.sv
// sine_phase_gen: phase-accumulator read address for a depth_p-entry sine table, advanced once per sample tick.
module sine_phase_gen
    import sine_gen_pkg::*;
#(
    parameter  int unsigned depth_p       = 100,
    parameter  int unsigned sample_div_p  = 4,
    localparam int unsigned addr_width_lp = $clog2(depth_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic [addr_width_lp-1:0] step_i,
    input  logic                     step_valid_i,
    output logic [addr_width_lp-1:0] addr_o,
    output logic                     sample_v_o,
    output logic                     wrap_o,
    output logic                     running_o
);
    state_t                   r_state;
    logic [addr_width_lp-1:0] r_addr, r_step, r_pend, w_step_c, w_next;
    logic                     r_pend_v, r_sv, r_wrap, w_run_en, w_tick;
    wrap_res_t                w_res;

    assign w_run_en = (r_state == RUN) && en_i;
    assign w_step_c = (32'(step_i) >= depth_p) ? addr_width_lp'(depth_p - 1) : step_i;
    assign w_res    = wrap_add(32'(r_addr), 32'(r_step), 32'(depth_p));
    assign w_next   = addr_width_lp'(w_res.addr);

    // Clearing whenever not running restarts the sample period from 0 on every RUN entry.
    sample_tick_div #(.div_p(sample_div_p)) u_div (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (!w_run_en),
        .en_i    (w_run_en),
        .tick_o  (w_tick)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_sv     <= 1'b0;
            r_wrap   <= 1'b0;
            r_step   <= addr_width_lp'(1);
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else if (r_state == IDLE) begin
            r_addr <= '0;
            r_sv   <= 1'b0;
            r_wrap <= 1'b0;
            if (step_valid_i) begin
                r_step   <= w_step_c;
                r_pend_v <= 1'b0;
            end
            if (en_i) r_state <= RUN;
        end else begin
            r_sv   <= w_tick;
            r_wrap <= w_tick && w_res.wrap;
            if (!en_i) begin
                r_state <= IDLE;
                r_addr  <= '0;
            end else if (w_tick) r_addr <= w_next;
            // A write landing on the tick edge replaces pend after the old pend has moved into step.
            if (w_tick && r_pend_v) begin
                r_step   <= r_pend;
                r_pend_v <= 1'b0;
            end
            if (step_valid_i) begin
                r_pend   <= w_step_c;
                r_pend_v <= 1'b1;
            end
        end
    end

    assign addr_o     = r_addr;
    assign sample_v_o = r_sv;
    assign wrap_o     = r_wrap;
    assign running_o  = (r_state == RUN);
endmodule

// File: tb/tb_sine_phase_gen.sv
// tb_sine_phase_gen: directed and randomized checks of sine_phase_gen against a cycle-level reference model.
module tb_sine_phase_gen;
    localparam int DEPTH = 100;
    localparam int DIV   = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0, reset = 1'b1, en = 1'b0, step_v = 1'b0;
    logic [AW-1:0] step = '0;
    logic [AW-1:0] addr;
    logic          sv, wrap, running;

    int checks = 0, errors = 0;
    int m_run, m_phase, m_addr, m_step, m_pend, m_pend_v, m_sv, m_wrap;
    int first, wraps, svs, wrap_addr;

    sine_phase_gen #(.depth_p(DEPTH), .sample_div_p(DIV)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .en_i         (en),
        .step_i       (step),
        .step_valid_i (step_v),
        .addr_o       (addr),
        .sample_v_o   (sv),
        .wrap_o       (wrap),
        .running_o    (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_phase = 0; m_addr = 0; m_step = 1;
        m_pend = 0; m_pend_v = 0; m_sv = 0; m_wrap = 0;
    endtask

    // One clock edge of the reference: phase counts RUN edges since entry; every DIV-th is a tick.
    task automatic model_edge(input int e, input int v, input int s);
        int c, total;
        c = (s >= DEPTH) ? DEPTH - 1 : s;
        if (m_run == 0) begin
            m_sv = 0; m_wrap = 0; m_addr = 0; m_phase = 0;
            if (v != 0) begin m_step = c; m_pend_v = 0; end
            m_run = e;
        end else if (e == 0) begin
            m_run = 0; m_sv = 0; m_wrap = 0; m_addr = 0; m_phase = 0;
            if (v != 0) begin m_pend = c; m_pend_v = 1; end
        end else begin
            m_phase++;
            m_sv = (m_phase % DIV == 0) ? 1 : 0;
            m_wrap = 0;
            if (m_sv != 0) begin
                total  = m_addr + m_step;
                m_wrap = (total >= DEPTH) ? 1 : 0;
                m_addr = total % DEPTH;
                if (m_pend_v != 0) begin m_step = m_pend; m_pend_v = 0; end
            end
            if (v != 0) begin m_pend = c; m_pend_v = 1; end
        end
    endtask

    task automatic check_all();
        chk("addr", int'(addr), m_addr);
        chk("sample_v", int'(sv), m_sv);
        chk("wrap", int'(wrap), m_wrap);
        chk("running", int'(running), m_run);
    endtask

    task automatic cyc(input int e, input int v, input int s);
        @(negedge clk);
        en = e[0]; step_v = v[0]; step = AW'(s);
        @(posedge clk);
        model_edge(e, v, s % (1 << AW));
        #1 check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_addr", int'(addr), 0);
        chk("rst_sv", int'(sv), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_running", int'(running), 0);
        reset = 1'b0;

        first = 0;
        for (int k = 1; k <= 13; k++) begin
            cyc(1, 0, 0);
            if (sv && first == 0) first = k;
        end
        chk("first_sv_latency", first, 5);
        chk("addr_step1", int'(addr), 3);

        cyc(0, 0, 0); cyc(0, 1, 7);
        wraps = 0; wrap_addr = -1;
        for (int k = 0; k < 61; k++) begin
            cyc(1, 0, 0);
            if (wrap) begin wraps++; wrap_addr = int'(addr); end
        end
        chk("step7_final", int'(addr), 5);
        chk("step7_wraps", wraps, 1);
        chk("step7_wrap_addr", wrap_addr, 5);

        cyc(0, 0, 0); cyc(0, 1, 99);
        wraps = 0;
        for (int k = 0; k < 41; k++) begin
            cyc(1, 0, 0);
            if (wrap) wraps++;
        end
        chk("step99_wraps", wraps, 9);
        chk("step99_final", int'(addr), 90);

        cyc(0, 0, 0); cyc(0, 1, 250);
        for (int k = 0; k < 5; k++) cyc(1, 0, 0);
        chk("clamp_250", int'(addr), 99);

        cyc(0, 0, 0); cyc(0, 1, 3); cyc(1, 0, 0);
        for (int r = 1; r <= 16; r++) cyc(1, (r == 6 || r == 8) ? 1 : 0, (r == 6) ? 10 : 20);
        chk("pend_order", int'(addr), 36);

        cyc(0, 0, 0); cyc(0, 1, 0);
        svs = 0; wraps = 0;
        for (int k = 0; k < 13; k++) begin
            cyc(1, 0, 0);
            if (sv) svs++;
            if (wrap) wraps++;
        end
        chk("step0_addr", int'(addr), 0);
        chk("step0_svs", svs, 3);
        chk("step0_wraps", wraps, 0);

        cyc(0, 0, 0); cyc(0, 1, 5);
        for (int k = 0; k < 7; k++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("drop_addr", int'(addr), 0);
        for (int k = 0; k < 5; k++) cyc(1, 0, 0);
        chk("resume_sv", int'(sv), 1);
        chk("resume_addr", int'(addr), 5);

        cyc(0, 0, 0); cyc(0, 1, 3);
        for (int k = 0; k < 9; k++) cyc(1, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_addr", int'(addr), 0);
        chk("async_sv", int'(sv), 0);
        chk("async_running", int'(running), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) cyc(0, 0, 0);

        for (int k = 0; k < 400; k++)
            cyc(($urandom_range(0, 9) != 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 127)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sine_phase_gen.md
Name: sine_phase_gen

Overview:
- Phase-accumulator address generator that drives the read address of the sine lookup stage (depth_p-entry table, async read).
- Each sample period it advances a table index by a programmable step, modulo depth_p. Output frequency = f_clk * step / (sample_div_p * depth_p).
- Provides a sample strobe and a once-per-period wrap strobe for downstream DAC/PWM and test logic.

Parameters:
- depth_p, 100: table depth. Any value >= 2; need not be a power of two.
- sample_div_p, 4: clocks per sample tick; >= 2.
- addr_width_lp, $clog2(depth_p): derived local parameter; address/step width.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- en_i  in  1  run enable. Level-sensitive.
- step_i  in  addr_width_lp  phase increment per sample.
- step_valid_i  in  1  one-cycle write strobe for step_i.
- addr_o  out  addr_width_lp  table read address; connect straight to the lookup rd_addr.
- sample_v_o  out  1  one-cycle pulse: addr_o just advanced.
- wrap_o  out  1  one-cycle pulse, coincident with sample_v_o, when the advance wrapped past depth_p-1.
- running_o  out  1  high in RUN.

Behaviour:
- Reset (async assert, any cycle): state=IDLE, addr_o=0, sample_v_o=0, wrap_o=0, running_o=0, tick counter=0, step_r=1, pend_v=0, pend=0.
- States:
  - IDLE: counter held 0; addr_o held 0 (downstream outputs the sine(0) sample). Leave IDLE when en_i=1; next cycle is RUN.
  - RUN: the counter counts 0..sample_div_p-1 and wraps. On the edge where count==sample_div_p-1, a tick occurs. Leave RUN when en_i=0; next cycle is IDLE.
  - IDLE entry forces addr_o=0 and counter=0. Any pulse in flight is dropped: sample_v_o=0 and wrap_o=0 on the cycle after leaving RUN.
- Tick edge:
  - sum = addr_o + step_r, computed at addr_width_lp+1 bits.
  - If sum >= depth_p: addr_o <= sum - depth_p and wrap_o <= 1. Else addr_o <= sum and wrap_o <= 0.
  - sample_v_o <= 1.
  - On all non-tick edges, sample_v_o and wrap_o are 0.
- Latency: the first tick after RUN entry happens on the sample_div_p-th RUN edge. sample_v_o and the new addr_o are visible together in the following cycle.
- Step handling:
  - step_i >= depth_p is clamped to depth_p-1 at capture.
  - In IDLE, step_valid_i writes step_r directly, effective immediately.
  - In RUN, step_valid_i writes pend and sets pend_v. At a tick, the increment uses the old step_r; after the tick, step_r <= pend and pend_v clears. A new step is therefore glitch-free and takes effect on the next tick.
  - step_valid_i on the tick cycle itself goes to pend and applies at the following tick.
  - Back-to-back writes before a tick: last write wins.
- step=0: addr_o holds, sample_v_o still pulses, wrap_o never asserts.
- en_i toggling mid-period: the counter restarts from 0 on every RUN entry. No partial ticks.
- Reset mid-run: everything returns to reset values immediately (async).

Decomposition:
- Package sine_gen_pkg:
  - state enum (IDLE, RUN), as a 1-bit typedef.
  - A pure function wrap_add(addr, step, depth) that returns the wrapped address and the wrap flag.
- Sub-module sample_tick_div: counter 0..sample_div_p-1 with clear_i and en_i; produces tick_o one cycle wide. This is the natural split; everything else stays in sine_phase_gen.

Test Plan (depth_p=100, sample_div_p=4):
- Reset then en_i=1, step=1 -> addr_o steps 1, 2, 3 … with sample_v_o every 4 clocks. First sample_v_o is 5 clocks after en_i rises. running_o=1.
- step=7 loaded in IDLE, run 15 ticks -> addr_o ends at 5 (sequence …91, 98, 5). wrap_o pulses exactly with the 98->5 transition. 105-100=5 checks the non-power-of-two modulo.
- step=99 -> addr_o 99, 98, 97 …, with wrap_o set on every tick except the first.
- step=250 written -> clamped to 99.
- In RUN with step=3, write step=10 two cycles before a tick, and write step=20 on the tick cycle -> that tick advances by 3, the next by 10, the one after by 20.
- step=0 -> addr_o constant, sample_v_o pulses, wrap_o=0.
- en_i dropped for 1 cycle mid-period -> addr_o=0 the next cycle; ticks resume 4 clocks after re-entry.
- reset_i asserted asynchronously between edges -> all outputs 0 immediately, no glitch pulse after release.
